// File: rtl/serial_transmitter.sv
// ---------------------------------------------------------------------------
// serial_transmitter
//   Buffers 7-bit words in a small FIFO and sends each one as a 10-bit-period
//   frame on a registered serial line: start (0), data bits 6..0 (MSB first),
//   even parity, stop (1). Frames are sent back to back while words remain
//   buffered, with no idle gap between them.
//
// Parameters
//   CLKS_PER_BIT : clock cycles per serial bit period (1..255)
//   FIFO_DEPTH   : input buffer entries (power of two, >= 2)
//
// Ports
//   clk        : clock, all state changes on the rising edge
//   rst        : synchronous active-high reset, overrides all other inputs
//   valid_in   : producer offers data_in this cycle
//   data_in    : 7-bit payload word
//   ready_out  : buffer not full; a word is taken when valid_in & ready_out
//   serial_out : registered serial line, idles at 1
//   busy       : transmitter FSM is not idle
//   fifo_count : number of buffered words not yet popped
// ---------------------------------------------------------------------------
module serial_transmitter #(
  parameter int CLKS_PER_BIT = 1,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          valid_in,
  input  logic [6:0]                    data_in,
  output logic                          ready_out,
  output logic                          serial_out,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t           state_q, state_d;
  logic [6:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [7:0]       bit_cnt_q, bit_cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [6:0]       shift_q;
  logic             parity_q;
  logic             serial_d;
  logic             bit_done;
  logic             buf_nonempty;
  logic             push;
  logic             pop;

  // Last cycle of the current bit period.
  assign bit_done     = (bit_cnt_q == 8'(CLKS_PER_BIT - 1));
  assign buf_nonempty = (fifo_count != '0);
  assign ready_out    = (fifo_count != CNT_W'(FIFO_DEPTH));
  assign push         = valid_in && ready_out;
  // A word is taken when leaving IDLE or at the end of a stop bit, always
  // judged on the registered count so a fresh push waits one edge.
  assign pop          = buf_nonempty && ((state_q == IDLE) || ((state_q == STOP) && bit_done));
  assign busy         = (state_q != IDLE);

  // State register and registered line.
  // NOTE: clocked state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      serial_out <= 1'b1;
      bit_cnt_q  <= '0;
      bit_idx_q  <= '0;
    end else begin
      state_q    <= state_d;
      serial_out <= serial_d;
      bit_cnt_q  <= bit_cnt_d;
      bit_idx_q  <= bit_idx_d;
    end
  end

  // Next-state logic.
  // NOTE: every combinational output gets a default first so no path leaves
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (buf_nonempty) state_d = START;
      START:   if (bit_done) state_d = DATA;
      DATA:    if (bit_done && (bit_idx_q == 3'd0)) state_d = PARITY;
      PARITY:  if (bit_done) state_d = STOP;
      STOP:    if (bit_done) state_d = buf_nonempty ? START : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output logic: bit timing, data index and the next line level.
  always_comb begin
    bit_idx_d = bit_idx_q;
    bit_cnt_d = ((state_q == IDLE) || bit_done) ? 8'd0 : bit_cnt_q + 8'd1;

    if ((state_q == START) && bit_done) begin
      bit_idx_d = 3'd6;
    end else if ((state_q == DATA) && bit_done && (bit_idx_q != 3'd0)) begin
      bit_idx_d = bit_idx_q - 3'd1;
    end

    case (state_d)
      IDLE:    serial_d = 1'b1;
      START:   serial_d = 1'b0;
      DATA:    serial_d = shift_q[bit_idx_d];
      PARITY:  serial_d = parity_q;
      STOP:    serial_d = 1'b1;
      default: serial_d = 1'b1;
    endcase
  end

  // Buffer bookkeeping and capture of the word being framed. The captured
  // copy keeps a frame in flight independent of later pushes.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      shift_q    <= '0;
      parity_q   <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr   <= rd_ptr + PTR_W'(1);
        shift_q  <= mem[rd_ptr];
        parity_q <= ^mem[rd_ptr];
      end
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CNT_W'(1);
        2'b01:   fifo_count <= fifo_count - CNT_W'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // NOTE: the storage array is deliberately not reset; an entry is only read
  // after it has been written, and leaving it reset-free lets it map to RAM.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= data_in;
    end
  end

endmodule

// File: tb/tb_serial_transmitter.sv
// ---------------------------------------------------------------------------
// tb_serial_transmitter
//   Drives two serial_transmitter instances (CLKS_PER_BIT = 1 and 3, both
//   FIFO_DEPTH = 4) with the same stimulus. Each lane has a frame-level model
//   (a queue of buffered words plus the cycles left in the current frame);
//   words the model starts sending are pushed into an expected queue, and a
//   monitor rebuilds frames from serial_out and compares them.
// ---------------------------------------------------------------------------
module tb_serial_transmitter;

  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic       clk = 1'b0;
  logic       rst;
  logic       valid_in;
  logic [6:0] data_in;

  int n_checks = 0;
  int n_errors = 0;
  int seen_n[2];
  int leftover[2];

  always #5 clk = ~clk;

  task automatic check(input int lane, input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL lane%0d %s: got %0d expected %0d", lane, name, act, exp);
    end
  endtask

  // Line level at bit period 'pos' of the frame carrying word 'd'.
  function automatic int frame_bit(input int d, input int pos);
    if (pos == 0) return 0;
    if (pos <= 7) return (d >> (7 - pos)) & 1;
    if (pos == 8) return $countones(d) & 1;
    return 1;
  endfunction

  for (genvar g = 0; g < 2; g++) begin : lane
    localparam int CPB = (g == 0) ? 1 : 3;

    logic          rdy_w;
    logic          ser_w;
    logic          busy_w;
    logic [CW-1:0] cnt_w;

    int pend_q[$];
    int exp_q[$];
    int frame_left = 0;

    serial_transmitter #(
      .CLKS_PER_BIT(CPB),
      .FIFO_DEPTH  (DEPTH)
    ) dut (
      .clk       (clk),
      .rst       (rst),
      .valid_in  (valid_in),
      .data_in   (data_in),
      .ready_out (rdy_w),
      .serial_out(ser_w),
      .busy      (busy_w),
      .fifo_count(cnt_w)
    );

    // Frame-level reference: a word starts its frame when the line is free
    // (idle, or last cycle of the previous frame) and was buffered before
    // this edge; a push is accepted only when fewer than DEPTH words wait.
    initial begin : model
      bit do_pop;
      bit do_push;
      forever begin
        @(posedge clk);
        if (rst) begin
          pend_q.delete();
          exp_q.delete();
          frame_left = 0;
        end else begin
          do_pop  = (pend_q.size() > 0) && (frame_left <= 1);
          do_push = valid_in && (pend_q.size() < DEPTH);
          if (do_pop) begin
            exp_q.push_back(pend_q.pop_front());
            frame_left = 10 * CPB;
          end else if (frame_left > 0) begin
            frame_left--;
          end
          if (do_push) pend_q.push_back(int'(data_in));
        end
        leftover[g] = pend_q.size() + exp_q.size();
      end
    end

    initial begin : monitor
      bit in_frame;
      int n, cur, act_bits, exp_bits, hold_err, pos, fb, lb;
      in_frame = 1'b0;
      n = 0; cur = 0; act_bits = 0; exp_bits = 0; hold_err = 0;
      seen_n[g] = 0;
      forever begin
        @(posedge clk);
        #2;
        check(g, "busy", int'(busy_w), int'(frame_left > 0));
        check(g, "fifo_count", int'(cnt_w), pend_q.size());
        check(g, "ready_out", int'(rdy_w), int'(pend_q.size() != DEPTH));
        lb = int'(ser_w);
        if (rst) in_frame = 1'b0;
        if (!in_frame) begin
          check(g, "line_idle_or_start", lb, (frame_left == 10 * CPB) ? 0 : 1);
          if ((frame_left == 10 * CPB) && (exp_q.size() > 0) && (lb == 0)) begin
            in_frame = 1'b1;
            n = 0; cur = exp_q[0]; act_bits = 0; exp_bits = 0; hold_err = 0;
          end
        end
        if (in_frame) begin
          pos = n / CPB;
          fb  = frame_bit(cur, pos);
          if (lb != fb) hold_err++;
          if ((n % CPB) == 0) begin
            act_bits |= lb << pos;
            exp_bits |= fb << pos;
          end
          n++;
          if (n == 10 * CPB) begin
            check(g, "frame_bits", act_bits, exp_bits);
            check(g, "bit_hold", hold_err, 0);
            check(g, "parity_xor", $countones(act_bits & 32'h1FE) % 2, 0);
            void'(exp_q.pop_front());
            seen_n[g]++;
            in_frame = 1'b0;
          end
        end
      end
    end
  end

  task automatic drive(input bit v, input int d, input bit r);
    valid_in = v;
    data_in  = 7'(d);
    rst      = r;
    @(negedge clk);
  endtask

  task automatic idle(input int cycles);
    repeat (cycles) drive(1'b0, 0, 1'b0);
  endtask

  initial begin
    int b0, b1;
    rst = 1'b1; valid_in = 1'b0; data_in = '0;
    repeat (3) drive(1'b0, 0, 1'b1);
    idle(2);

    // Single frames into an idle block.
    drive(1'b1, 'h55, 1'b0); idle(40);
    drive(1'b1, 'h07, 1'b0); idle(40);

    // Back-to-back words: second start bit follows the first stop bit.
    drive(1'b1, 'h01, 1'b0);
    drive(1'b1, 'h7F, 1'b0);
    idle(70);

    drive(1'b1, 'h40, 1'b0); idle(40);

    // One frame in flight, then five pushes: four buffered, fifth dropped.
    b0 = seen_n[0]; b1 = seen_n[1];
    drive(1'b1, 'h11, 1'b0);
    idle(2);
    for (int i = 0; i < 5; i++) drive(1'b1, 'h12 + i, 1'b0);
    idle(200);
    check(0, "five_frames", seen_n[0] - b0, 5);
    check(1, "five_frames", seen_n[1] - b1, 5);

    // Reset in the middle of a frame: no frame completes, line goes idle.
    b0 = seen_n[0]; b1 = seen_n[1];
    drive(1'b1, 'h2A, 1'b0);
    idle(3);
    drive(1'b0, 0, 1'b1);
    idle(40);
    check(0, "aborted_frame", seen_n[0] - b0, 0);
    check(1, "aborted_frame", seen_n[1] - b1, 0);

    // Random traffic with occasional resets.
    for (int i = 0; i < 1500; i++) begin
      drive($urandom_range(0, 2) == 0, int'($urandom_range(0, 127)), $urandom_range(0, 499) == 0);
    end
    idle(400);
    check(0, "drained", leftover[0], 0);
    check(1, "drained", leftover[1], 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
